alu_arbiter: RTL

- Shares one combinational ALU instance between NUM_REQ requesters, e.g. execute-stage integer ops and the branch-compare unit.
- Uses round-robin arbitration with valid/ready handshakes on both the request and response sides.
- Has a single registered output stage, so accepted-to-result latency is exactly 1 cycle.
- Sits between the decode/execute control and the ALU; requesters never drive the ALU directly.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu.sv | 41 ++++
 rtl/alu_rr_grant.sv | 36 +++
 rtl/alu_arbiter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the shared-ALU arbiter slice.
//   ALU_OP_W : width of an ALU operation code
//   XLEN     : default operand/result width
//   alu_op_e : 4-bit ALU operation codes (code 15 is undefined)
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned XLEN     = 32;

  typedef enum logic [ALU_OP_W-1:0] {
    ADD                        = 4'd0,
    SUB                        = 4'd1,
    OR                         = 4'd2,
    XOR                        = 4'd3,
    AND                        = 4'd4,
    LesserThanUnsigned         = 4'd5,
    LesserThanSigned           = 4'd6,
    ShiftRightUnsigned         = 4'd7,
    ShiftLeftUnsigned          = 4'd8,
    ShiftRightSigned           = 4'd9,
    ShiftLeftSigned            = 4'd10,
    GreaterThanOrEqualUnsigned = 4'd11,
    GreaterThanOrEqualSigned   = 4'd12,
    Equal                      = 4'd13,
    NotEqual                   = 4'd14
  } alu_op_e;

endpackage

// File: rtl/alu.sv
// alu: combinational integer ALU shared by the arbiter's requesters.
//   op  : operation code (alu_pkg::alu_op_e); undefined codes yield 0
//   x,y : operands; shift amount is y[4:0]
//   res : result; compares return 0/1 zero-extended
module alu
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = alu_pkg::XLEN
) (
  input  logic [ALU_OP_W-1:0] op,
  input  logic [XLEN-1:0]     x,
  input  logic [XLEN-1:0]     y,
  output logic [XLEN-1:0]     res
);

  logic [4:0] sh;
  assign sh = y[4:0];

  always_comb begin
    res = '0;
    case (op)
      ADD:                        res = x + y;
      SUB:                        res = x - y;
      OR:                         res = x | y;
      XOR:                        res = x ^ y;
      AND:                        res = x & y;
      LesserThanUnsigned:         res = {{(XLEN-1){1'b0}}, x < y};
      LesserThanSigned:           res = {{(XLEN-1){1'b0}}, $signed(x) < $signed(y)};
      ShiftRightUnsigned:         res = x >> sh;
      ShiftLeftUnsigned:          res = x << sh;
      ShiftRightSigned:           res = $signed(x) >>> sh;
      ShiftLeftSigned:            res = x << sh;
      GreaterThanOrEqualUnsigned: res = {{(XLEN-1){1'b0}}, x >= y};
      GreaterThanOrEqualSigned:   res = {{(XLEN-1){1'b0}}, $signed(x) >= $signed(y)};
      Equal:                      res = {{(XLEN-1){1'b0}}, x == y};
      NotEqual:                   res = {{(XLEN-1){1'b0}}, x != y};
      default:                    res = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_grant.sv
// alu_rr_grant: purely combinational round-robin picker.
//   req : request vector
//   ptr : index searched first; search wraps modulo NUM_REQ
//   en  : when low, no grant is issued
//   gnt : one-hot grant (or zero)
//   idx : index of the granted requester (0 when none)
module alu_rr_grant #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      idx
);

  logic        found;
  int unsigned cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = (32'(ptr) + off) % NUM_REQ;
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU among NUM_REQ requesters with
// round-robin arbitration and a single registered output stage (1-cycle
// accept-to-result latency). Optional macro: ALU_ARB_STATS_EN adds
// per-requester saturating 16-bit grant counters.
//   clk, reset_n : clock, synchronous active-low reset
//   req_valid/req_ready : request handshake (req_ready one-hot or zero)
//   req_op/req_x/req_y  : packed per-requester op code and operands
//   rsp_valid/rsp_ready : response handshake (rsp_valid one-hot)
//   rsp_data            : registered ALU result
//   busy                : output stage occupied
//   stats_clr, grant_count : only with ALU_ARB_STATS_EN
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN    = alu_pkg::XLEN
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [ALU_OP_W*NUM_REQ-1:0]  req_op,
  input  logic [XLEN*NUM_REQ-1:0]      req_x,
  input  logic [XLEN*NUM_REQ-1:0]      req_y,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [XLEN-1:0]              rsp_data,
  output logic                         busy
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic                         stats_clr,
  output logic [16*NUM_REQ-1:0]        grant_count
`endif
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {EMPTY, FULL} stage_e;

  stage_e              state_q, state_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]     rsp_data_q, rsp_data_d;
  logic [PW-1:0]       owner_q, owner_d;
  logic [PW-1:0]       ptr_q, ptr_d;

  logic                can_accept;
  logic [NUM_REQ-1:0]  gnt;
  logic [PW-1:0]       gnt_idx;
  logic                accept;
  logic [ALU_OP_W-1:0] alu_op;
  logic [XLEN-1:0]     alu_x, alu_y, alu_res;

  // A held result blocks new grants until its owner drains it.
  assign can_accept = (state_q == EMPTY) || rsp_ready[owner_q];

  alu_rr_grant #(.NUM_REQ(NUM_REQ), .PW(PW)) u_grant (
    .req (req_valid),
    .ptr (ptr_q),
    .en  (can_accept && reset_n),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign accept = |gnt;
  assign alu_op = req_op[gnt_idx*ALU_OP_W +: ALU_OP_W];
  assign alu_x  = req_x[gnt_idx*XLEN +: XLEN];
  assign alu_y  = req_y[gnt_idx*XLEN +: XLEN];

  alu #(.XLEN(XLEN)) u_alu (
    .op  (alu_op),
    .x   (alu_x),
    .y   (alu_y),
    .res (alu_res)
  );

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    if (accept) begin
      state_d     = FULL;
      rsp_valid_d = gnt;
      rsp_data_d  = alu_res;
      owner_d     = gnt_idx;
      ptr_d       = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end else if ((state_q == FULL) && rsp_ready[owner_q]) begin
      state_d     = EMPTY;
      rsp_valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      owner_q     <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q == FULL);

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (!reset_n || stats_clr) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (accept && (cnt_q[gnt_idx] != '1)) begin
      cnt_q[gnt_idx] <= cnt_q[gnt_idx] + 16'd1;
    end
  end

  always_comb begin
    grant_count = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) grant_count[16*i +: 16] = cnt_q[i];
  end
`endif

endmodule
